cordic_vec_engine: RTL and testbench
====================================

# cordic_vec_engine

Iterative CORDIC vectoring-mode responder for the FastICA update path. It serves the `ica_cordic_vec_*` request interface that the update controller drives. It accepts an (x, y) pair and returns the gain-compensated magnitude, quadrant code and optional angle. It also streams per-stage micro-rotation directions so a companion rotation engine can run in lockstep. One request is in flight at a time; one micro-rotation is performed per cycle.

## Interface
- `DATA_WIDTH`, 16: I/O sample width, signed.
- `FRAC_WIDTH`, 10: I/O fractional bits. Informational only; the engine is scale-agnostic.
- `CORDIC_WIDTH`, 22: internal datapath width. Guard shift `G = CORDIC_WIDTH-DATA_WIDTH-2` (4).
- `ANGLE_WIDTH`, 16: signed angle; full scale ±π = ±2^(ANGLE_WIDTH-1).
- `CORDIC_STAGES`, 16: number of micro-rotations.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `nrst` in 1: soft reset, synchronous, active-low. Same effect as `rst_n`; driven by controller `cordic_nrst`.
- `en` in 1: request strobe; single-cycle pulse.
- `xin`, `yin` in DATA_WIDTH: signed operands, sampled with `en`.
- `angle_calc_en` in 1: sampled with `en`; enables angle accumulation.
- `microRot_out_start` out 1: one-cycle pulse marking stage 0 of the direction stream.
- `microRot_dir` out 1: direction of the current stage; 1 = y≥0 (clockwise).
- `microRot_out` out CORDIC_STAGES: all directions, bit i = stage i. Valid with `opvld`.
- `quad_out` out 2: `{xin<0, yin<0}`.
- `xout` out DATA_WIDTH: compensated, saturated magnitude.
- `angle_out` out ANGLE_WIDTH: vector angle. 0 if angle accumulation was disabled.
- `opvld` out 1: one-cycle result pulse.
- `busy` out 1: high from accept until `opvld`, exclusive.
- `ovf` out 1: sticky. Set when a request is dropped. Cleared only by reset.

## Operation
- States: IDLE, ITER, COMP, DONE.
- Accept:
  - `en`=1 in IDLE or DONE accepts the request.
  - `en` in ITER or COMP is ignored and sets `ovf`; the current request is unaffected.
- On accept:
  - Sign-extend operands to CORDIC_WIDTH, then shift left by G.
  - If x<0, negate both operands (180° pre-rotation) and seed angle = +π (`2^(AW-1)`, wraps mod 2π). Otherwise seed angle = 0.
  - Latch `quad_out` and `angle_calc_en`, clear stage counter k, go to ITER.
- ITER, stage k:
  - d = (y≥0).
  - If d: x += y>>>k, y −= x>>>k, z += atan(2^-k).
  - Else: x −= y>>>k, y += x>>>k, z −= atan(2^-k).
  - All right-hand sides use pre-update values. Shifts are arithmetic.
  - `microRot_dir`=d, `microRot_out[k]`=d.
  - The atan ROM holds CORDIC_STAGES entries, rounded to nearest in ANGLE_WIDTH format.
  - After k = CORDIC_STAGES-1, go to COMP.
- COMP:
  - p = x·19898 (0.6072529·2^15).
  - r = p>>>(15+G), rounded half-up.
  - Saturate r to [−2^(DW−1), 2^(DW−1)−1]; x≥0 always.
  - Go to DONE.
- DONE:
  - `opvld`=1 for one cycle.
  - Return to IDLE, or to ITER if `en` is accepted in this same cycle.
- `angle_out` = z when the latched `angle_calc_en`=1, else 0.
- `xout`, `angle_out`, `microRot_out` and `quad_out` hold until the next `opvld` or next accept (`quad_out`).
- Zero vector: xout=0, quad=00. Directions are all 1 and angle = residual of the all-clockwise sum. This is legal and requires no special case.

## Timing
- Accept in cycle T.
- Cycle T+1 (stage 0 of the direction stream):
  - `microRot_out_start`=1.
  - `quad_out` is valid from this cycle.
  - `microRot_dir` carries the stage-0 direction.
- Cycles T+1..T+CORDIC_STAGES: `microRot_dir` carries stage k in cycle T+1+k.
- Cycle T+CORDIC_STAGES+1: COMP.
- Cycle T+CORDIC_STAGES+2: `opvld`=1. Latency is 18 cycles at default parameters.
- Back-to-back: `en` during the `opvld` cycle is accepted, giving one result every CORDIC_STAGES+2 cycles.
- Reset (`rst_n` or `nrst` low at an edge), including mid-operation:
  - Next cycle: state IDLE.
  - All outputs 0: `opvld`, `busy`, `ovf`, `microRot_out_start`, `microRot_dir`, `microRot_out`, `quad_out`, `xout`, `angle_out`.
  - No stale `opvld` is produced afterwards.
- Reset has priority over `en` in the same cycle.
- `busy` = state ∈ {ITER, COMP}.

## Test plan
- **First quadrant, angle on.** xin=3072, yin=4096 (3.0, 4.0 in Q10), `angle_calc_en`=1:
  - `microRot_out_start` at T+1 with `quad_out`=00.
  - `opvld` at T+18 with xout=5120±2, angle_out=9672±16.
- **Second quadrant.** xin=−3072, yin=4096 → quad_out=10, xout=5120±2, angle_out=23095±16.
- **Saturation and angle gating.** xin=yin=32767 with `angle_calc_en`=0 → xout=32767, angle_out=0.
- **Drop while busy.** Second `en` at T+5 → ignored, `ovf`=1 from T+6, first result unchanged. Pulsing `nrst` then clears `ovf`.
- **Reset mid-operation.** `rst_n` low at T+8 → all outputs 0 at T+9, no `opvld` at T+18. A new request after reset completes in 18 cycles.
- **Back-to-back.** `en` asserted in the `opvld` cycle (T+18) → second `microRot_out_start` at T+19 and second `opvld` at T+36.

Source files
------------

// File: rtl/cordic_vec_engine.sv
// Iterative CORDIC vectoring engine. It performs one micro-rotation per cycle and returns the
// gain-compensated magnitude, quadrant and optional angle, plus a per-stage direction stream.
module cordic_vec_engine #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FRAC_WIDTH    = 10,
  parameter int unsigned CORDIC_WIDTH  = 22,
  parameter int unsigned ANGLE_WIDTH   = 16,
  parameter int unsigned CORDIC_STAGES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nrst,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    xin,
  input  logic [DATA_WIDTH-1:0]    yin,
  input  logic                     angle_calc_en,
  output logic                     microRot_out_start,
  output logic                     microRot_dir,
  output logic [CORDIC_STAGES-1:0] microRot_out,
  output logic [1:0]               quad_out,
  output logic [DATA_WIDTH-1:0]    xout,
  output logic [ANGLE_WIDTH-1:0]   angle_out,
  output logic                     opvld,
  output logic                     busy,
  output logic                     ovf
);

  localparam int unsigned Guard = CORDIC_WIDTH - DATA_WIDTH - 2;
  localparam int unsigned KW    = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;
  localparam int unsigned PW    = CORDIC_WIDTH + 16;
  localparam int unsigned RSH   = 15 + Guard;
  localparam logic signed [PW-1:0] GainComp  = PW'(19898);
  localparam logic signed [PW-1:0] RoundHalf = PW'(1) <<< (RSH - 1);
  localparam logic signed [PW-1:0] SatHi     = PW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SatLo     = -SatHi - PW'(1);

  // The arctangent table below is scaled for a 16-bit angle word.
  if (CORDIC_WIDTH < DATA_WIDTH + 2 || FRAC_WIDTH >= DATA_WIDTH || ANGLE_WIDTH != 16)
  begin : g_param_check
    $error("cordic_vec_engine: unsupported parameter set");
  end

  typedef enum logic [1:0] {StIdle, StIter, StComp, StDone} state_e;
  state_e state_q, state_d;

  logic signed [CORDIC_WIDTH-1:0] x_q, y_q, x_ext, y_ext, x_seed, y_seed;
  logic signed [CORDIC_WIDTH-1:0] x_sh, y_sh, x_nxt, y_nxt;
  logic signed [ANGLE_WIDTH-1:0]  z_q, z_seed, z_nxt, atan_k;
  logic signed [PW-1:0]           prod, rounded;
  logic [KW-1:0]                  k_q;
  logic [CORDIC_STAGES-1:0]       dirs_q, rot_q;
  logic [DATA_WIDTH-1:0]          xout_q, mag_sat;
  logic [ANGLE_WIDTH-1:0]         angle_q;
  logic [1:0]                     quad_q;
  logic                           ang_en_q, ovf_q, dir, accept, last_stage, clear;

  // atan(2^-k) in units of pi/2^15, rounded to nearest.
  function automatic logic signed [ANGLE_WIDTH-1:0] atan_rom(input logic [KW-1:0] idx);
    logic [15:0] v;
    case (int'(idx))
      0:       v = 16'd8192;
      1:       v = 16'd4836;
      2:       v = 16'd2555;
      3:       v = 16'd1297;
      4:       v = 16'd651;
      5:       v = 16'd326;
      6:       v = 16'd163;
      7:       v = 16'd81;
      8:       v = 16'd41;
      9:       v = 16'd20;
      10:      v = 16'd10;
      11:      v = 16'd5;
      12:      v = 16'd3;
      13:      v = 16'd1;
      14:      v = 16'd1;
      default: v = 16'd0;
    endcase
    return ANGLE_WIDTH'(v);
  endfunction

  assign clear      = ~rst_n | ~nrst;
  assign accept     = en && (state_q == StIdle || state_q == StDone);
  assign last_stage = (k_q == KW'(CORDIC_STAGES - 1));

  always_comb begin
    x_ext  = CORDIC_WIDTH'($signed(xin)) <<< Guard;
    y_ext  = CORDIC_WIDTH'($signed(yin)) <<< Guard;
    x_seed = x_ext;
    y_seed = y_ext;
    z_seed = '0;
    // Left half-plane: rotate by 180 degrees first so the iterations always converge.
    if (xin[DATA_WIDTH-1]) begin
      x_seed = -x_ext;
      y_seed = -y_ext;
      z_seed = {1'b1, {(ANGLE_WIDTH - 1){1'b0}}};
    end
    dir    = ~y_q[CORDIC_WIDTH-1];
    x_sh   = x_q >>> k_q;
    y_sh   = y_q >>> k_q;
    atan_k = atan_rom(k_q);
    if (dir) begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + atan_k;
    end else begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - atan_k;
    end
    prod    = PW'(x_q) * GainComp;
    rounded = (prod + RoundHalf) >>> RSH;
    if (rounded > SatHi) begin
      mag_sat = SatHi[DATA_WIDTH-1:0];
    end else if (rounded < SatLo) begin
      mag_sat = SatLo[DATA_WIDTH-1:0];
    end else begin
      mag_sat = rounded[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StIter;
      StIter:  if (last_stage) state_d = StComp;
      StComp:  state_d = StDone;
      StDone:  state_d = en ? StIter : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy               = 1'b0;
    opvld              = 1'b0;
    microRot_out_start = 1'b0;
    microRot_dir       = 1'b0;
    unique case (state_q)
      StIter: begin
        busy               = 1'b1;
        microRot_out_start = (k_q == '0);
        microRot_dir       = dir;
      end
      StComp:  busy = 1'b1;
      StDone:  opvld = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      k_q      <= '0;
      dirs_q   <= '0;
      rot_q    <= '0;
      quad_q   <= '0;
      ang_en_q <= 1'b0;
      xout_q   <= '0;
      angle_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        x_q      <= x_seed;
        y_q      <= y_seed;
        z_q      <= z_seed;
        k_q      <= '0;
        quad_q   <= {xin[DATA_WIDTH-1], yin[DATA_WIDTH-1]};
        ang_en_q <= angle_calc_en;
      end else if (state_q == StIter) begin
        x_q         <= x_nxt;
        y_q         <= y_nxt;
        z_q         <= z_nxt;
        k_q         <= k_q + KW'(1);
        dirs_q[k_q] <= dir;
      end else if (state_q == StComp) begin
        xout_q  <= mag_sat;
        angle_q <= ang_en_q ? z_q : '0;
        rot_q   <= dirs_q;
      end
      if (en && (state_q == StIter || state_q == StComp)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign microRot_out = rot_q;
  assign quad_out     = quad_q;
  assign xout         = xout_q;
  assign angle_out    = angle_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_cordic_vec_engine.sv
`timescale 1ns/1ps
// Bench for cordic_vec_engine. It checks directed quadrant, saturation, drop, reset and
// back-to-back cases, plus random vectors against a real-arithmetic magnitude/angle model.
module tb_cordic_vec_engine;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int NS  = 16;
  localparam int LAT = NS + 2;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nrst = 1'b1;
  logic en = 1'b0;
  logic angle_calc_en = 1'b0;
  logic signed [DW-1:0] xin = '0;
  logic signed [DW-1:0] yin = '0;
  logic microRot_out_start, microRot_dir, opvld, busy, ovf;
  logic [NS-1:0] microRot_out;
  logic [1:0] quad_out;
  logic signed [DW-1:0] xout;
  logic signed [AW-1:0] angle_out;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cordic_vec_engine dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .nrst              (nrst),
    .en                (en),
    .xin               (xin),
    .yin               (yin),
    .angle_calc_en     (angle_calc_en),
    .microRot_out_start(microRot_out_start),
    .microRot_dir      (microRot_dir),
    .microRot_out      (microRot_out),
    .quad_out          (quad_out),
    .xout              (xout),
    .angle_out         (angle_out),
    .opvld             (opvld),
    .busy              (busy),
    .ovf               (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_mag(int x, int y);
    real m;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    return (m > 32767.0) ? 32767 : int'(m);
  endfunction

  function automatic int model_ang(int x, int y);
    return int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
  endfunction

  function automatic logic [1:0] model_quad(int x, int y);
    return {x < 0, y < 0};
  endfunction

  // First micro-rotation direction: sign of y after the half-plane fold.
  function automatic logic model_d0(int x, int y);
    return (x < 0) ? (-y >= 0) : (y >= 0);
  endfunction

  function automatic int ang_err(int got, int exp);
    logic signed [15:0] d;
    d = 16'(got - exp);
    return (d < 0) ? -int'(d) : int'(d);
  endfunction

  function automatic int abs_i(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Issue one request and capture the T+1 stream signals and the result at opvld.
  task automatic run_req(input int x, input int y, input logic ae, output int lat,
                         output logic st, output logic dd, output logic [1:0] q,
                         output int xo, output int ao, output logic [NS-1:0] rot);
    xin = 16'(x);
    yin = 16'(y);
    angle_calc_en = ae;
    en = 1'b1;
    step();
    en = 1'b0;
    st = microRot_out_start;
    dd = microRot_dir;
    q = quad_out;
    lat = 1;
    while (opvld !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    xo = int'(xout);
    ao = int'(angle_out);
    rot = microRot_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    xin = 16'sd100;
    yin = 16'sd5;
    repeat (3) step();
    n_cmp++;
    if ({opvld, busy, ovf, microRot_out_start, microRot_dir} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {opvld, busy, ovf, microRot_out_start, microRot_dir});
    end
    n_cmp++;
    if (microRot_out !== '0 || quad_out !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rot_quad: got %h/%b, expected 0/00", microRot_out, quad_out);
    end
    n_cmp++;
    if (xout !== '0 || angle_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d/%0d, expected 0/0", xout, angle_out);
    end
    en = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_quadrant();
    int lat, xo, ao;
    logic st, dd;
    logic [1:0] q;
    logic [NS-1:0] rot;
    run_req(3072, 4096, 1'b1, lat, st, dd, q, xo, ao, rot);
    n_cmp++;
    if (st !== 1'b1 || q !== 2'b00 || dd !== 1'b1) begin
      n_fail++;
      $display("FAIL q1_start: got start=%b quad=%b dir=%b, expected 1/00/1", st, q, dd);
    end
    n_cmp++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL q1_latency: got %0d, expected %0d", lat, LAT);
    end
    n_cmp++;
    if (abs_i(xo - model_mag(3072, 4096)) > 2) begin
      n_fail++;
      $display("FAIL q1_xout: got %0d, expected %0d+-2", xo, model_mag(3072, 4096));
    end
    n_cmp++;
    if (ang_err(ao, model_ang(3072, 4096)) > 16) begin
      n_fail++;
      $display("FAIL q1_angle: got %0d, expected %0d+-16", ao, model_ang(3072, 4096));
    end
  endtask

  task automatic test_second_quadrant();
    int lat, xo, ao;
    logic st, dd;
    logic [1:0] q;
    logic [NS-1:0] rot;
    run_req(-3072, 4096, 1'b1, lat, st, dd, q, xo, ao, rot);
    n_cmp++;
    if (q !== 2'b10) begin
      n_fail++;
      $display("FAIL q2_quad: got %b, expected 10", q);
    end
    n_cmp++;
    if (abs_i(xo - model_mag(-3072, 4096)) > 2) begin
      n_fail++;
      $display("FAIL q2_xout: got %0d, expected %0d+-2", xo, model_mag(-3072, 4096));
    end
    n_cmp++;
    if (ang_err(ao, model_ang(-3072, 4096)) > 16) begin
      n_fail++;
      $display("FAIL q2_angle: got %0d, expected %0d+-16", ao, model_ang(-3072, 4096));
    end
  endtask

  task automatic test_saturation();
    int lat, xo, ao;
    logic st, dd;
    logic [1:0] q;
    logic [NS-1:0] rot;
    run_req(32767, 32767, 1'b0, lat, st, dd, q, xo, ao, rot);
    n_cmp++;
    if (xo != 32767) begin
      n_fail++;
      $display("FAIL sat_xout: got %0d, expected 32767", xo);
    end
    n_cmp++;
    if (ao != 0) begin
      n_fail++;
      $display("FAIL sat_angle_gated: got %0d, expected 0", ao);
    end
  endtask

  task automatic test_zero_vector();
    int lat, xo, ao, exp_ang;
    logic st, dd;
    logic [1:0] q;
    logic [NS-1:0] rot;
    exp_ang = 0;
    for (int k = 0; k < NS; k++) begin
      exp_ang += int'($atan(1.0 / real'(1 << k)) * 32768.0 / PI);
    end
    run_req(0, 0, 1'b1, lat, st, dd, q, xo, ao, rot);
    n_cmp++;
    if (xo != 0 || q !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_xout_quad: got %0d/%b, expected 0/00", xo, q);
    end
    n_cmp++;
    if (rot !== {NS{1'b1}}) begin
      n_fail++;
      $display("FAIL zero_dirs: got %h, expected all ones", rot);
    end
    n_cmp++;
    if (ao != exp_ang) begin
      n_fail++;
      $display("FAIL zero_angle: got %0d, expected %0d", ao, exp_ang);
    end
  endtask

  task automatic test_drop();
    int lat;
    xin = 16'sd1500;
    yin = -16'sd2500;
    angle_calc_en = 1'b1;
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (4) step();
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_ovf_before: got %b, expected 0", ovf);
    end
    xin = 16'sd7;
    yin = 16'sd9;
    en = 1'b1;
    step();
    en = 1'b0;
    n_cmp++;
    if (ovf !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_ovf_set: got ovf=%b busy=%b, expected 1/1", ovf, busy);
    end
    lat = 6;
    while (opvld !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    n_cmp++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL drop_latency: got %0d, expected %0d", lat, LAT);
    end
    n_cmp++;
    if (abs_i(int'(xout) - model_mag(1500, -2500)) > 3 || quad_out !== 2'b01 ||
        ang_err(int'(angle_out), model_ang(1500, -2500)) > 16) begin
      n_fail++;
      $display("FAIL drop_result: got %0d/%0d/%b, expected %0d/%0d/01", xout, angle_out,
               quad_out, model_mag(1500, -2500), model_ang(1500, -2500));
    end
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    n_cmp++;
    if (ovf !== 1'b0 || xout !== '0 || opvld !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_nrst_clear: got ovf=%b xout=%0d opvld=%b, expected 0/0/0", ovf,
               xout, opvld);
    end
  endtask

  task automatic test_reset_mid();
    int lat, xo, ao, seen;
    logic st, dd;
    logic [1:0] q;
    logic [NS-1:0] rot;
    run_req(2000, 1000, 1'b1, lat, st, dd, q, xo, ao, rot);
    xin = -16'sd1000;
    yin = -16'sd2000;
    en = 1'b1;
    step();
    en = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({opvld, busy, microRot_out_start, microRot_dir} !== 4'b0 || quad_out !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_flags: got %b quad=%b, expected 0000 quad=00",
               {opvld, busy, microRot_out_start, microRot_dir}, quad_out);
    end
    n_cmp++;
    if (xout !== '0 || angle_out !== '0 || microRot_out !== '0) begin
      n_fail++;
      $display("FAIL rstmid_data: got %0d/%0d/%h, expected 0/0/0", xout, angle_out,
               microRot_out);
    end
    seen = 0;
    repeat (12) begin
      step();
      if (opvld === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_stale_opvld: got %0d pulses, expected 0", seen);
    end
    run_req(-1000, -2000, 1'b1, lat, st, dd, q, xo, ao, rot);
    n_cmp++;
    if (lat != LAT || q !== 2'b11 || abs_i(xo - model_mag(-1000, -2000)) > 3) begin
      n_fail++;
      $display("FAIL rstmid_recover: got lat=%0d quad=%b xout=%0d, expected %0d/11/%0d", lat,
               q, xo, LAT, model_mag(-1000, -2000));
    end
  endtask

  task automatic test_back_to_back();
    int lat, xo, ao;
    logic st, dd;
    logic [1:0] q;
    logic [NS-1:0] rot;
    run_req(5000, -700, 1'b1, lat, st, dd, q, xo, ao, rot);
    n_cmp++;
    if (lat != LAT || abs_i(xo - model_mag(5000, -700)) > 3) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d xout=%0d, expected %0d/%0d", lat, xo, LAT,
               model_mag(5000, -700));
    end
    // Accept the next request in the opvld cycle itself.
    run_req(-6000, -6000, 1'b1, lat, st, dd, q, xo, ao, rot);
    n_cmp++;
    if (st !== 1'b1 || q !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_start: got start=%b quad=%b, expected 1/11", st, q);
    end
    n_cmp++;
    if (lat != LAT || abs_i(xo - model_mag(-6000, -6000)) > 3 ||
        ang_err(ao, model_ang(-6000, -6000)) > 16) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d xout=%0d angle=%0d, expected %0d/%0d/%0d", lat,
               xo, ao, LAT, model_mag(-6000, -6000), model_ang(-6000, -6000));
    end
  endtask

  task automatic test_random();
    int lat, xo, ao, x, y;
    logic st, dd, ae;
    logic [1:0] q;
    logic [NS-1:0] rot;
    for (int i = 0; i < 24; i++) begin
      x = int'($signed(16'($urandom)));
      y = int'($signed(16'($urandom)));
      ae = 1'($urandom);
      // Very short vectors lose angle resolution; keep them out of the random set.
      if (abs_i(x) + abs_i(y) < 2048) x = 12345;
      run_req(x, y, ae, lat, st, dd, q, xo, ao, rot);
      n_cmp++;
      if (lat != LAT || st !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_timing[%0d]: got lat=%0d start=%b, expected %0d/1", i, lat, st, LAT);
      end
      n_cmp++;
      if (q !== model_quad(x, y) || dd !== model_d0(x, y) || rot[0] !== model_d0(x, y)) begin
        n_fail++;
        $display("FAIL rnd_quad_dir[%0d] (%0d,%0d): got %b/%b/%b, expected %b/%b", i, x, y, q,
                 dd, rot[0], model_quad(x, y), model_d0(x, y));
      end
      n_cmp++;
      if (abs_i(xo - model_mag(x, y)) > 3) begin
        n_fail++;
        $display("FAIL rnd_xout[%0d] (%0d,%0d): got %0d, expected %0d+-3", i, x, y, xo,
                 model_mag(x, y));
      end
      n_cmp++;
      if (ae ? (ang_err(ao, model_ang(x, y)) > 16) : (ao != 0)) begin
        n_fail++;
        $display("FAIL rnd_angle[%0d] (%0d,%0d) en=%b: got %0d, expected %0d", i, x, y, ae, ao,
                 ae ? model_ang(x, y) : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_quadrant();
    test_second_quadrant();
    test_saturation();
    test_zero_vector();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
